// File: rtl/game_state_fsm.sv
// Round phase controller: turns start/pause button edges into round timer controls,
// detects end of round and generates the blinking low-time HUD warning.
module game_state_fsm #(
    parameter logic [7:0] LOW_TIME     = 8'd30,
    parameter logic [5:0] BLINK_FRAMES = 6'd15
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       vsync,
    input  logic       start_btn,
    input  logic       pause_btn,
    input  logic [7:0] time_left,
    output logic       restart,
    output logic       timer_go,
    output logic [2:0] game_state,
    output logic       game_over_pulse,
    output logic       low_time_blink
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RESTART   = 3'd1,
        S_PLAY      = 3'd2,
        S_PAUSED    = 3'd3,
        S_GAME_OVER = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic       start_q, pause_q, vsync_q;
    logic [1:0] vs_cnt_q, vs_cnt_d;
    logic [5:0] blink_cnt_q, blink_cnt_d;
    logic       blink_phase_q, blink_phase_d;
    logic       game_over_pulse_q, game_over_pulse_d;

    logic       start_rise, pause_rise, vs_fall, warn_active;

    // Button history resets high so a button held through reset cannot fire.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q           <= S_IDLE;
            start_q           <= 1'b1;
            pause_q           <= 1'b1;
            vsync_q           <= 1'b0;
            vs_cnt_q          <= 2'd0;
            blink_cnt_q       <= 6'd0;
            blink_phase_q     <= 1'b1;
            game_over_pulse_q <= 1'b0;
        end else begin
            state_q           <= state_d;
            start_q           <= start_btn;
            pause_q           <= pause_btn;
            vsync_q           <= vsync;
            vs_cnt_q          <= vs_cnt_d;
            blink_cnt_q       <= blink_cnt_d;
            blink_phase_q     <= blink_phase_d;
            game_over_pulse_q <= game_over_pulse_d;
        end
    end

    always_comb begin
        start_rise  = start_btn & ~start_q;
        pause_rise  = pause_btn & ~pause_q;
        vs_fall     = vsync_q & ~vsync;
        warn_active = ((state_q == S_PLAY) || (state_q == S_PAUSED)) &&
                      (time_left != 8'd0) && (time_left <= LOW_TIME);

        state_d       = state_q;
        vs_cnt_d      = vs_cnt_q;
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;

        case (state_q)
            S_IDLE: begin
                if (start_rise) state_d = S_RESTART;
            end
            S_RESTART: begin
                // Leave on the second frame boundary so the timer sees restart for a full frame.
                if (vs_fall) begin
                    if (vs_cnt_q != 2'd3) vs_cnt_d = vs_cnt_q + 2'd1;
                    if (vs_cnt_q >= 2'd1) state_d = S_PLAY;
                end
            end
            S_PLAY: begin
                if (time_left == 8'd0)  state_d = S_GAME_OVER;
                else if (pause_rise)    state_d = S_PAUSED;
            end
            S_PAUSED: begin
                if (start_rise)         state_d = S_RESTART;
                else if (pause_rise)    state_d = S_PLAY;
            end
            S_GAME_OVER: begin
                if (start_rise) state_d = S_RESTART;
            end
            default: state_d = S_IDLE;
        endcase

        if ((state_d == S_RESTART) && (state_q != S_RESTART)) vs_cnt_d = 2'd0;

        // Blink timing only advances while playing; pausing freezes it mid-period.
        if (!warn_active) begin
            blink_cnt_d   = 6'd0;
            blink_phase_d = 1'b1;
        end else if ((state_q == S_PLAY) && vs_fall) begin
            if (blink_cnt_q == (BLINK_FRAMES - 6'd1)) begin
                blink_cnt_d   = 6'd0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d   = blink_cnt_q + 6'd1;
            end
        end

        game_over_pulse_d = (state_d == S_GAME_OVER) && (state_q != S_GAME_OVER);
    end

    assign restart         = (state_q == S_IDLE) || (state_q == S_RESTART);
    assign timer_go        = (state_q == S_PLAY);
    assign game_state      = state_q;
    assign game_over_pulse = game_over_pulse_q;
    assign low_time_blink  = warn_active & blink_phase_q;

endmodule

// File: tb/tb_game_state_fsm.sv
// Randomised and directed bench for game_state_fsm, checked against a frame-counting
// reference model of the round phase rules.
module tb_game_state_fsm;

    localparam logic [7:0] LT = 8'd30;
    localparam int         BF = 15;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       vsync;
    logic       start_btn;
    logic       pause_btn;
    logic [7:0] time_left;
    logic       restart;
    logic       timer_go;
    logic [2:0] game_state;
    logic       game_over_pulse;
    logic       low_time_blink;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: phase as an integer, frames counted as plain totals.
    int mState;
    bit mStartPrev, mPausePrev, mVsPrev;
    int mFalls;
    int mWarnFalls;
    bit mPulse;

    always #5 clock = ~clock;

    game_state_fsm #(.LOW_TIME(8'd30), .BLINK_FRAMES(6'd15)) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .vsync           (vsync),
        .start_btn       (start_btn),
        .pause_btn       (pause_btn),
        .time_left       (time_left),
        .restart         (restart),
        .timer_go        (timer_go),
        .game_state      (game_state),
        .game_over_pulse (game_over_pulse),
        .low_time_blink  (low_time_blink)
    );

    function automatic bit warnNow();
        return ((mState == 2) || (mState == 3)) && (time_left != 8'd0) && (time_left <= LT);
    endfunction

    // {game_state, restart, timer_go, game_over_pulse, low_time_blink}
    function automatic logic [6:0] expVec();
        logic [2:0] st;
        bit phaseOn;
        st = mState[2:0];
        phaseOn = ((mWarnFalls / BF) % 2) == 0;
        return {st, 1'(mState <= 1), 1'(mState == 2), mPulse, 1'(warnNow() && phaseOn)};
    endfunction

    function automatic logic [6:0] obsVec();
        return {game_state, restart, timer_go, game_over_pulse, low_time_blink};
    endfunction

    task automatic modelReset();
        mState = 0; mStartPrev = 1; mPausePrev = 1; mVsPrev = 0;
        mFalls = 0; mWarnFalls = 0; mPulse = 0;
    endtask

    task automatic cycle();
        bit sr, pr, vf, warn;
        int ns, nf, nw;
        if (!reset_n) begin
            @(posedge clock); #1;
            modelReset();
            return;
        end
        sr = start_btn && !mStartPrev;
        pr = pause_btn && !mPausePrev;
        vf = mVsPrev && !vsync;
        warn = warnNow();
        ns = mState;
        case (mState)
            0: if (sr) ns = 1;
            1: if (vf && (mFalls + 1 >= 2)) ns = 2;
            2: if (time_left == 8'd0) ns = 4; else if (pr) ns = 3;
            3: if (sr) ns = 1; else if (pr) ns = 2;
            4: if (sr) ns = 1;
            default: ns = 0;
        endcase
        nf = mFalls;
        if (mState == 1 && vf) nf = nf + 1;
        if (ns == 1 && mState != 1) nf = 0;
        nw = mWarnFalls;
        if (!warn) nw = 0;
        else if (mState == 2 && vf) nw = nw + 1;
        @(posedge clock); #1;
        mPulse = (ns == 4) && (mState != 4);
        mState = ns; mFalls = nf; mWarnFalls = nw;
        mStartPrev = start_btn; mPausePrev = pause_btn; mVsPrev = vsync;
    endtask

    task automatic fall();
        vsync = 1'b1; cycle();
        vsync = 1'b0; cycle();
    endtask

    task automatic goPlay();
        start_btn = 1'b0; pause_btn = 1'b0; cycle();
        start_btn = 1'b1; cycle();
        fall(); fall();
        start_btn = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start_btn = 1'b1; pause_btn = 1'b1; vsync = 1'b0; time_left = 8'd50;
        modelReset();
        #12;
        compared++;
        if (obsVec() !== 7'b000_1_0_0_0) begin
            mismatched++;
            $display("[TB] FAIL reset_values: got %b expected %b", obsVec(), 7'b0001000);
        end
        @(negedge clock); reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            compared++;
            if (game_state !== 3'd0 || restart !== 1'b1 || obsVec() !== expVec()) begin
                mismatched++;
                $display("[TB] FAIL held_start_idle: got %b expected %b", obsVec(), expVec());
            end
        end
    endtask

    task automatic test_start();
        start_btn = 1'b0; pause_btn = 1'b0; cycle();
        start_btn = 1'b1; cycle();
        compared++;
        if (game_state !== 3'd1 || obsVec() !== expVec()) begin
            mismatched++;
            $display("[TB] FAIL start_to_restart: got %b expected %b", obsVec(), expVec());
        end
        fall();
        compared++;
        if (game_state !== 3'd1 || obsVec() !== expVec()) begin
            mismatched++;
            $display("[TB] FAIL restart_one_fall: got %b expected %b", obsVec(), expVec());
        end
        fall();
        compared++;
        if (game_state !== 3'd2 || timer_go !== 1'b1 || restart !== 1'b0 || obsVec() !== expVec()) begin
            mismatched++;
            $display("[TB] FAIL restart_to_play: got %b expected %b", obsVec(), expVec());
        end
        start_btn = 1'b0;
    endtask

    task automatic test_round_end();
        time_left = 8'd2; cycle();
        time_left = 8'd1; cycle();
        compared++;
        if (game_state !== 3'd2 || obsVec() !== expVec()) begin
            mismatched++;
            $display("[TB] FAIL countdown_play: got %b expected %b", obsVec(), expVec());
        end
        time_left = 8'd0; cycle();
        compared++;
        if (game_state !== 3'd4 || game_over_pulse !== 1'b1 || timer_go !== 1'b0 || restart !== 1'b0
            || obsVec() !== expVec()) begin
            mismatched++;
            $display("[TB] FAIL game_over_entry: got %b expected %b", obsVec(), expVec());
        end
        cycle();
        compared++;
        if (game_state !== 3'd4 || game_over_pulse !== 1'b0 || obsVec() !== expVec()) begin
            mismatched++;
            $display("[TB] FAIL game_over_pulse_width: got %b expected %b", obsVec(), expVec());
        end
    endtask

    task automatic test_pause_resume();
        time_left = 8'd100;
        goPlay();
        pause_btn = 1'b1; cycle();
        compared++;
        if (game_state !== 3'd3 || timer_go !== 1'b0 || obsVec() !== expVec()) begin
            mismatched++;
            $display("[TB] FAIL pause: got %b expected %b", obsVec(), expVec());
        end
        pause_btn = 1'b0; cycle();
        pause_btn = 1'b1; cycle();
        compared++;
        if (game_state !== 3'd2 || obsVec() !== expVec()) begin
            mismatched++;
            $display("[TB] FAIL resume: got %b expected %b", obsVec(), expVec());
        end
        pause_btn = 1'b0; cycle();
        pause_btn = 1'b1; cycle();
        pause_btn = 1'b0; start_btn = 1'b0; cycle();
        pause_btn = 1'b1; start_btn = 1'b1; cycle();
        compared++;
        if (game_state !== 3'd1 || obsVec() !== expVec()) begin
            mismatched++;
            $display("[TB] FAIL paused_start_priority: got %b expected %b", obsVec(), expVec());
        end
        fall(); fall();
        start_btn = 1'b0; pause_btn = 1'b0;
    endtask

    task automatic test_simultaneous();
        cycle();
        time_left = 8'd0; pause_btn = 1'b1; cycle();
        compared++;
        if (game_state !== 3'd4 || obsVec() !== expVec()) begin
            mismatched++;
            $display("[TB] FAIL zero_beats_pause: got %b expected %b", obsVec(), expVec());
        end
        pause_btn = 1'b0;
    endtask

    task automatic test_blink();
        time_left = 8'd100;
        goPlay();
        time_left = 8'd31; cycle();
        compared++;
        if (low_time_blink !== 1'b0 || obsVec() !== expVec()) begin
            mismatched++;
            $display("[TB] FAIL blink_above_threshold: got %b expected %b", obsVec(), expVec());
        end
        time_left = 8'd30; #1;
        compared++;
        if (low_time_blink !== 1'b1 || obsVec() !== expVec()) begin
            mismatched++;
            $display("[TB] FAIL blink_at_threshold: got %b expected %b", obsVec(), expVec());
        end
        for (int i = 0; i < 14; i++) fall();
        compared++;
        if (low_time_blink !== 1'b1 || obsVec() !== expVec()) begin
            mismatched++;
            $display("[TB] FAIL blink_before_toggle: got %b expected %b", obsVec(), expVec());
        end
        fall();
        compared++;
        if (low_time_blink !== 1'b0 || obsVec() !== expVec()) begin
            mismatched++;
            $display("[TB] FAIL blink_toggle_off: got %b expected %b", obsVec(), expVec());
        end
        for (int i = 0; i < 15; i++) fall();
        compared++;
        if (low_time_blink !== 1'b1 || obsVec() !== expVec()) begin
            mismatched++;
            $display("[TB] FAIL blink_toggle_on: got %b expected %b", obsVec(), expVec());
        end
        for (int i = 0; i < 15; i++) fall();
        pause_btn = 1'b1; cycle();
        for (int i = 0; i < 20; i++) fall();
        compared++;
        if (game_state !== 3'd3 || low_time_blink !== 1'b0 || obsVec() !== expVec()) begin
            mismatched++;
            $display("[TB] FAIL blink_frozen_paused: got %b expected %b", obsVec(), expVec());
        end
        time_left = 8'd0; #1;
        compared++;
        if (low_time_blink !== 1'b0 || obsVec() !== expVec()) begin
            mismatched++;
            $display("[TB] FAIL blink_zero_time: got %b expected %b", obsVec(), expVec());
        end
        time_left = 8'd10;
        pause_btn = 1'b0; cycle();
        pause_btn = 1'b1; cycle();
        pause_btn = 1'b0;
        time_left = 8'd0; cycle();
        compared++;
        if (game_state !== 3'd4 || low_time_blink !== 1'b0 || obsVec() !== expVec()) begin
            mismatched++;
            $display("[TB] FAIL blink_game_over: got %b expected %b", obsVec(), expVec());
        end
    endtask

    task automatic test_reset_mid();
        time_left = 8'd100;
        goPlay();
        cycle();
        #2 reset_n = 1'b0;
        #1;
        modelReset();
        compared++;
        if (timer_go !== 1'b0 || restart !== 1'b1 || game_state !== 3'd0 || obsVec() !== expVec()) begin
            mismatched++;
            $display("[TB] FAIL async_reset_play: got %b expected %b", obsVec(), expVec());
        end
        cycle(); cycle();
        @(negedge clock); reset_n = 1'b1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 29) == 0) start_btn = ~start_btn;
            if ($urandom_range(0, 24) == 0) pause_btn = ~pause_btn;
            if ($urandom_range(0, 2) == 0)  vsync = ~vsync;
            if ($urandom_range(0, 19) == 0) time_left = 8'($urandom_range(0, 45));
            if ($urandom_range(0, 299) == 0) time_left = 8'd0;
            cycle();
            compared++;
            if (obsVec() !== expVec()) begin
                mismatched++;
                $display("[TB] FAIL random_cycle_%0d: got %b expected %b", i, obsVec(), expVec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_round_end();
        test_pause_resume();
        test_simultaneous();
        test_blink();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
